// File: rtl/ball_engine.sv
// Pong-style ball engine: serve countdown, ball motion with wall and paddle
// reflection, point scoring, and game-over/restart handling.
module ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 100,
  parameter int P1_X        = 20,
  parameter int P2_X        = 610,
  parameter int SPEED_X     = 1,
  parameter int SPEED_Y     = 1,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               restart,
  input  logic [9:0]         p1_y,
  input  logic [9:0]         p2_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         state,
  output logic               bounce,
  output logic               point_p1,
  output logic               point_p2,
  output logic               game_over
);

  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

  localparam logic [9:0]        CX     = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]        CY     = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] L_FACE = 12'(P1_X + PADDLE_W);
  localparam logic signed [11:0] R_FACE = 12'(P2_X - BALL_SIZE);
  localparam logic signed [11:0] B_SZ   = 12'(BALL_SIZE);
  localparam logic signed [11:0] P_H    = 12'(PADDLE_H);
  localparam logic signed [11:0] SPX    = 12'(SPEED_X);
  localparam logic signed [11:0] SPY    = 12'(SPEED_Y);
  localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } st_t;

  st_t                st_q, st_d;
  logic [9:0]         bx_q, bx_d, by_q, by_d;
  logic               dx_q, dx_d, dy_q, dy_d;   // 1 = moving toward +x / +y
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               scorer_q, scorer_d;       // 1 = P1 won the pending point
  logic               go_q, go_d;
  logic               bounce_q, bounce_d, pp1_q, pp1_d, pp2_q, pp2_d;

  logic signed [11:0] cur_x, cur_y, nx, ny, p1t, p2t;
  logic               l_hit, r_hit, wall, hit;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  // Candidate ball position and paddle-face crossing detection for this tick.
  always_comb begin
    cur_x  = signed'({2'b00, bx_q});
    cur_y  = signed'({2'b00, by_q});
    p1t    = signed'({2'b00, p1_y});
    p2t    = signed'({2'b00, p2_y});
    nx     = dx_q ? cur_x + SPX : cur_x - SPX;
    ny     = dy_q ? cur_y + SPY : cur_y - SPY;
    l_hit  = !dx_q && (cur_x >= L_FACE) && (nx <= L_FACE) &&
             (cur_y + B_SZ > p1t) && (cur_y < p1t + P_H);
    r_hit  = dx_q && (cur_x <= R_FACE) && (nx >= R_FACE) &&
             (cur_y + B_SZ > p2t) && (cur_y < p2t + P_H);
    s1_inc = s1_q + SCORE_W'(1);
    s2_inc = s2_q + SCORE_W'(1);
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    st_d     = st_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    scorer_d = scorer_q;
    go_d     = go_q;
    bounce_d = 1'b0;
    pp1_d    = 1'b0;
    pp2_d    = 1'b0;
    wall     = 1'b0;
    hit      = 1'b0;
    case (st_q)
      S_SERVE: begin
        if (tick) begin
          bx_d = CX;
          by_d = CY;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d = '0;
            st_d  = S_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (ny < 12'sd0) begin
            by_d = '0;
            dy_d = 1'b1;
            wall = 1'b1;
          end else if (ny > Y_MAX) begin
            by_d = Y_MAX[9:0];
            dy_d = 1'b0;
            wall = 1'b1;
          end else begin
            by_d = ny[9:0];
          end
          // Paddle faces are checked before the screen edges so a ball
          // touching a paddle at the edge is returned, not scored.
          if (l_hit) begin
            bx_d = L_FACE[9:0];
            dx_d = 1'b1;
            hit  = 1'b1;
          end else if (r_hit) begin
            bx_d = R_FACE[9:0];
            dx_d = 1'b0;
            hit  = 1'b1;
          end else if (nx < 12'sd0) begin
            scorer_d = 1'b0;
            st_d     = S_POINT;
          end else if (nx > X_MAX) begin
            scorer_d = 1'b1;
            st_d     = S_POINT;
          end else begin
            bx_d = nx[9:0];
          end
          bounce_d = wall | hit;
        end
      end
      S_POINT: begin
        if (scorer_q) begin
          s1_d  = s1_inc;
          pp1_d = 1'b1;
        end else begin
          s2_d  = s2_inc;
          pp2_d = 1'b1;
        end
        if ((scorer_q ? s1_inc : s2_inc) == WIN) begin
          st_d = S_OVER;
          go_d = 1'b1;
        end else begin
          st_d  = S_SERVE;
          bx_d  = CX;
          by_d  = CY;
          cnt_d = CNT_W'(SERVE_TICKS);
          // Serve heads toward the player who just scored.
          dx_d  = !scorer_q;
        end
      end
      S_OVER: begin
        if (restart) begin
          s1_d  = '0;
          s2_d  = '0;
          bx_d  = CX;
          by_d  = CY;
          cnt_d = CNT_W'(SERVE_TICKS);
          go_d  = 1'b0;
          st_d  = S_SERVE;
        end
      end
      default: st_d = S_SERVE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q     <= S_SERVE;
      bx_q     <= CX;
      by_q     <= CY;
      dx_q     <= 1'b1;
      dy_q     <= 1'b0;
      cnt_q    <= CNT_W'(SERVE_TICKS);
      s1_q     <= '0;
      s2_q     <= '0;
      scorer_q <= 1'b0;
      go_q     <= 1'b0;
      bounce_q <= 1'b0;
      pp1_q    <= 1'b0;
      pp2_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      scorer_q <= scorer_d;
      go_q     <= go_d;
      bounce_q <= bounce_d;
      pp1_q    <= pp1_d;
      pp2_q    <= pp2_d;
    end
  end

  assign state     = st_q;
  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign score_p1  = s1_q;
  assign score_p2  = s2_q;
  assign bounce    = bounce_q;
  assign point_p1  = pp1_q;
  assign point_p2  = pp2_q;
  assign game_over = go_q;

endmodule
